// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline inter-stage register: occupancy
// states, the NOP instruction word and the PC value presented by an
// empty slot.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned INSTR_W   = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] PC_RESET  = 16'h0000;

  // Number of held entries for a given occupancy state.
  function automatic logic [1:0] occ_of(input pipe_state_t st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage stall/bubble statistics.
// Clears only on the synchronous active-low reset and sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, holding at the maximum value once reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1'b1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register built as a two-entry skid buffer.
// in_ready and every out_* field come straight from flops, so neither side
// of the handshake sees a combinational path through this stage.
// Optional statistics counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PC_W      = 16,
  parameter logic [15:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  import pipe_pkg::*;

  localparam logic [PC_W-1:0]   PC_EMPTY   = PC_W'(PC_RESET);
  localparam logic [DATA_W-1:0] DATA_EMPTY = {DATA_W{1'b0}};

  pipe_state_t       state_r, state_nxt_s;
  logic [15:0]       skid_instr_r, skid_instr_nxt_s;
  logic [PC_W-1:0]   skid_pc_r, skid_pc_nxt_s;
  logic [DATA_W-1:0] skid_data_r, skid_data_nxt_s;
  logic [15:0]       main_instr_nxt_s;
  logic [PC_W-1:0]   main_pc_nxt_s;
  logic [DATA_W-1:0] main_data_nxt_s;
  logic              in_ready_nxt_s, out_valid_nxt_s;
  logic [1:0]        occupancy_nxt_s;
  logic              accept_s, deliver_s;

  assign accept_s  = in_valid & in_ready;
  assign deliver_s = out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next occupancy state; flush wins over accept and deliver.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) state_nxt_s = ONE;
          else          state_nxt_s = EMPTY;
        end
        ONE: begin
          if (accept_s && !deliver_s)      state_nxt_s = FULL;
          else if (deliver_s && !accept_s) state_nxt_s = EMPTY;
          else                             state_nxt_s = ONE;
        end
        FULL: begin
          if (deliver_s) state_nxt_s = ONE;
          else           state_nxt_s = FULL;
        end
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // Next contents of main and skid slots; an empty main slot holds the NOP view.
  always_comb begin
    main_instr_nxt_s = out_instr;
    main_pc_nxt_s    = out_pc;
    main_data_nxt_s  = out_data;
    skid_instr_nxt_s = skid_instr_r;
    skid_pc_nxt_s    = skid_pc_r;
    skid_data_nxt_s  = skid_data_r;
    if (flush) begin
      main_instr_nxt_s = NOP_INSTR;
      main_pc_nxt_s    = PC_EMPTY;
      main_data_nxt_s  = DATA_EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_instr_nxt_s = in_instr;
            main_pc_nxt_s    = in_pc;
            main_data_nxt_s  = in_data;
          end else begin
            main_instr_nxt_s = NOP_INSTR;
          end
        end
        ONE: begin
          if (accept_s && deliver_s) begin
            main_instr_nxt_s = in_instr;
            main_pc_nxt_s    = in_pc;
            main_data_nxt_s  = in_data;
          end else if (accept_s) begin
            skid_instr_nxt_s = in_instr;
            skid_pc_nxt_s    = in_pc;
            skid_data_nxt_s  = in_data;
          end else if (deliver_s) begin
            main_instr_nxt_s = NOP_INSTR;
            main_pc_nxt_s    = PC_EMPTY;
            main_data_nxt_s  = DATA_EMPTY;
          end else begin
            main_instr_nxt_s = out_instr;
          end
        end
        FULL: begin
          if (deliver_s) begin
            main_instr_nxt_s = skid_instr_r;
            main_pc_nxt_s    = skid_pc_r;
            main_data_nxt_s  = skid_data_r;
          end else begin
            main_instr_nxt_s = out_instr;
          end
        end
        default: begin
          main_instr_nxt_s = NOP_INSTR;
          main_pc_nxt_s    = PC_EMPTY;
          main_data_nxt_s  = DATA_EMPTY;
        end
      endcase
    end
  end

  // Handshake and occupancy outputs decoded from the next state.
  always_comb begin
    in_ready_nxt_s  = (state_nxt_s != FULL);
    out_valid_nxt_s = (state_nxt_s != EMPTY);
    occupancy_nxt_s = occ_of(state_nxt_s);
  end

  // Output and slot registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      occupancy    <= 2'd0;
      out_instr    <= NOP_INSTR;
      out_pc       <= PC_EMPTY;
      out_data     <= DATA_EMPTY;
      skid_instr_r <= NOP_INSTR;
      skid_pc_r    <= PC_EMPTY;
      skid_data_r  <= DATA_EMPTY;
    end else begin
      in_ready     <= in_ready_nxt_s;
      out_valid    <= out_valid_nxt_s;
      occupancy    <= occupancy_nxt_s;
      out_instr    <= main_instr_nxt_s;
      out_pc       <= main_pc_nxt_s;
      out_data     <= main_data_nxt_s;
      skid_instr_r <= skid_instr_nxt_s;
      skid_pc_r    <= skid_pc_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~out_valid & out_ready),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by
// randomized traffic, all compared against a queue-based FIFO model.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned CNT_W   = 4;
  localparam logic [15:0] NOP     = 16'h0800;
  localparam int          CNT_MAX = 15;

  typedef struct packed {
    logic [15:0]       instr;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0]       in_instr, out_instr;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  ent_t q[$];
  int   stall_m, bubble_m;
  int   vectors, miscompares;
  bit   offer_done;

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int sz = q.size();
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("in_ready",  32'(in_ready),  32'(sz < 2));
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("out_instr", 32'(out_instr), (sz > 0) ? 32'(q[0].instr) : 32'(NOP));
    chk("out_pc",    32'(out_pc),    (sz > 0) ? 32'(q[0].pc)    : 32'd0);
    chk("out_data",  32'(out_data),  (sz > 0) ? 32'(q[0].data)  : 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt",  32'(stall_cnt),  32'(stall_m));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(bubble_m));
`endif
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    int sz = q.size();
    bit acc = in_valid && (sz < 2);
    bit del = (sz > 0) && out_ready;
    ent_t e;
    e.instr = in_instr; e.pc = in_pc; e.data = in_data;
    if (!rst) begin
      q.delete();
      stall_m = 0;
      bubble_m = 0;
    end else begin
      if (sz > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
      if (sz == 0 && out_ready && bubble_m < CNT_MAX) bubble_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (del) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    offer_done = !rst || flush || acc;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic offer(input logic [15:0] i, input logic [PC_W-1:0] p, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_instr = i; in_pc = p; in_data = d;
  endtask

  initial begin
    vectors = 0; miscompares = 0; stall_m = 0; bubble_m = 0;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    offer(16'h1111, 16'h0010, 16'hAAAA);

    // Reset with in_valid held high.
    tick(); tick();
    chk("rst_nop", 32'(out_instr), 32'h0800);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();

    // Streaming, one entry per cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer(16'h4001 + 16'(k), 16'(2 * k), 16'(16'h0100 + k));
      tick();
      chk("stream_occ_le1", 32'(occupancy <= 2'd1), 32'd1);
    end
    in_valid = 1'b0;
    tick(); tick();

    // Three entries with downstream stalled; third must wait.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(16'h5001 + 16'(k), 16'(16'h0040 + 2 * k), 16'(16'h0200 + k));
      offer_done = 1'b0;
      for (int t = 0; t < 3 && !offer_done; t++) tick();
    end
    chk("full_occ", 32'(occupancy), 32'd2);
    chk("full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    offer_done = 1'b0;
    for (int t = 0; t < 4 && !offer_done; t++) tick();
    chk("third_accepted", 32'(offer_done), 32'd1);
    in_valid = 1'b0;
    for (int t = 0; t < 4; t++) tick();

    // Flush while FULL with a new entry offered.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer(16'h6001 + 16'(k), 16'(16'h0080 + 2 * k), 16'(16'h0300 + k));
      tick();
    end
    offer(16'h6EEE, 16'h00EE, 16'hEEEE);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick(); tick();

    // Reset in state ONE with a deliver pending.
    out_ready = 1'b0;
    offer(16'h7001, 16'h0100, 16'h7777);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("midrst_instr", 32'(out_instr), 32'h0800);
    rst = 1'b1;
    offer(16'h7002, 16'h0102, 16'h7778);
    tick();
    in_valid = 1'b0;
    tick();

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation and exact bubble counting.
    rst = 1'b0; tick(); rst = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    chk("bubble_exact", 32'(bubble_cnt), 32'd6);
    out_ready = 1'b0;
    offer(16'h8001, 16'h0200, 16'h8888);
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) tick();
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_keeps_stall", 32'(stall_cnt), 32'd15);
`endif

    // Randomized traffic; upstream holds an offer until it is taken.
    in_valid = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        offer(16'($urandom()), 16'($urandom()), 16'($urandom()));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 79) != 0);
      tick();
      if (offer_done) in_valid = 1'b0;
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage register for the pipelined successor of the five-stage fetch/decode/execute/memory/wb datapath. Each stage boundary gets one instance carrying the instruction word, PC and a stage-specific payload. Transfers use a valid/ready handshake through a two-entry skid buffer, so full throughput is kept with a registered `in_ready`. A synchronous flush supports branch/jump squashing, and empty slots present a NOP to the downstream stage.

## Interface
- `DATA_W`, 16: stage payload width (ALU result, read data, control bundle); must be ≥1
- `PC_W`, 16: PC width
- `NOP_INSTR`, 16'h0800: instruction word driven when no entry is valid
- `CNT_W`, 16: perf counter width (used only with the perf macro)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `flush`  in  1  discard all held entries
- `in_valid`  in  1  upstream entry offered
- `in_ready`  out  1  buffer can accept (registered)
- `in_instr`  in  16  instruction word
- `in_pc`  in  PC_W  PC of instruction
- `in_data`  in  DATA_W  payload
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream accepts head
- `out_instr`  out  16  head instruction, or NOP_INSTR when empty
- `out_pc`  out  PC_W  head PC, or 0 when empty
- `out_data`  out  DATA_W  head payload, or 0 when empty
- `occupancy`  out  2  entries held (0..2)
- `stall_cnt`  out  CNT_W  perf only: cycles with out_valid & !out_ready
- `bubble_cnt`  out  CNT_W  perf only: cycles with !out_valid & out_ready

## Operation
- Handshake rules:
  - Accept happens when in_valid & in_ready.
  - Deliver happens when out_valid & out_ready.
  - Entries are strictly FIFO: no reorder, duplicate or drop except on flush.
- States:
  - EMPTY (occupancy 0)
  - ONE (occupancy 1, main slot)
  - FULL (occupancy 2, main + skid)
- Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept & !deliver → FULL; deliver & !accept → EMPTY; both → ONE with the new entry in main.
  - FULL: deliver → ONE (skid moves to main). Accept is impossible in FULL.
- in_ready = (state != FULL). It is a pure function of registered state and has no combinational path from out_ready.
- out_valid = (state != EMPTY). The out_* fields are driven only from the main slot.
- Flush:
  - Takes priority over accept and deliver.
  - Next state is EMPTY.
  - An input offered in the flush cycle is dropped, and in_ready is not forced low.
  - A deliver in the flush cycle still counts for the downstream stage (data was presented).
- Reset (rst=0 at a clock edge), from any state and even mid-transfer:
  - state EMPTY, in_ready=1, out_valid=0
  - out_instr=NOP_INSTR, out_pc=0, out_data=0
  - occupancy=0, perf counters 0
- in_valid may be raised without waiting for in_ready. Upstream must hold its entry stable until it is accepted.

## Timing
- Latency: an entry accepted at edge N is on out_* after edge N, i.e. in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready drops the cycle after the second entry is accepted with no delivery. It rises the cycle after a delivery from FULL.
- Flush asserted in cycle N: out_valid=0 and occupancy=0 in cycle N+1.
- No combinational paths from inputs to any output.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - stall_cnt and bubble_cnt exist.
  - Each increments by 1 per qualifying cycle and saturates at all-ones.
  - Both clear only on reset; flush does not clear them.
- `PIPE_STAGE_PERF_EN` undefined: both ports and their logic are absent.

## Structure
- Shared package `pipe_pkg`:
  - `pipe_state_t` enum {EMPTY, ONE, FULL}
  - `NOP_INSTR` default constant
  - `PC_RESET` (16'h0000)
- Sub-module `sat_counter` (width param, inc, rst), instanced twice under `PIPE_STAGE_PERF_EN`.

## Test plan
- Reset with in_valid=1 held: in_ready=1, out_valid=0, out_instr=16'h0800, occupancy=0.
- Stream instr 16'h4001..16'h4005, PCs 0,2,4,6,8, out_ready=1: one delivered per cycle, in order, 1-cycle latency, occupancy stays ≤1.
- Send 3 entries with out_ready=0: first two accepted, occupancy=2, in_ready=0, third held. Raise out_ready: order is 1,2,3 with no loss.
- FULL, then flush=1 with in_valid=1 in the same cycle: next cycle occupancy=0, out_valid=0, offered entry never appears.
- Drive rst=0 for one cycle while in state ONE with a deliver pending: next cycle all outputs at reset values, later traffic unaffected.
- PERF on, CNT_W=4: hold out_valid=1 with out_ready=0 for 20 cycles → stall_cnt=15 (saturated); bubble_cnt counts idle out_ready=1 cycles exactly.
